// File: rtl/heap_pkg.sv
// Shared types and constants for the custom heap instruction execute stage.
package heap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } heap_state_t;

  localparam logic [6:0] HEAP_OPCODE = 7'b0001011;
  localparam logic [2:0] F3_PUSH     = 3'b000;
  localparam logic [2:0] F3_POP      = 3'b001;

endpackage

// File: rtl/heap_child_sel.sv
// Sift-down helper: picks the smaller valid child of idx and decides whether
// it must be swapped with the parent. Equal keys never swap; ties pick the left child.
module heap_child_sel
  import heap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [DATA_W-1:0] parent_key_i,
  input  logic [DATA_W-1:0] left_key_i,
  input  logic [DATA_W-1:0] right_key_i,
  output logic [IDX_W-1:0]  left_idx_o,
  output logic [IDX_W-1:0]  right_idx_o,
  output logic [IDX_W-1:0]  child_idx_o,
  output logic [DATA_W-1:0] child_key_o,
  output logic              swap_o
);

  // Two extra bits so 2*idx+2 never wraps before the bound check.
  localparam int W = IDX_W + 2;

  logic [W-1:0] left_w;
  logic [W-1:0] right_w;
  logic [W-1:0] count_w;
  logic         left_ok;
  logic         right_ok;
  logic         pick_right;

  always_comb begin
    left_w      = {1'b0, idx_i, 1'b1};
    right_w     = left_w + W'(1);
    count_w     = W'(count_i);
    left_ok     = left_w < count_w;
    right_ok    = right_w < count_w;
    pick_right  = right_ok && (right_key_i < left_key_i);
    left_idx_o  = IDX_W'(left_w);
    right_idx_o = IDX_W'(right_w);
    child_idx_o = pick_right ? right_idx_o : left_idx_o;
    child_key_o = pick_right ? right_key_i : left_key_i;
    swap_o      = left_ok && (child_key_o < parent_key_i);
  end

endmodule

// File: rtl/heap_exec_unit.sv
// Execute stage for the custom PUSH/POP heap instructions: a private register
// min-heap with one sift level per cycle and a single-cycle writeback pulse.
//
// state     | meaning
// IDLE      | ready; accepts a request or answers an illegal one directly
// SIFT_UP   | new key bubbling toward the root after a PUSH
// SIFT_DOWN | relocated last key sinking after a POP; result held in result_q
module heap_exec_unit
  import heap_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic [DATA_W-1:0] req_data,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic              resp_wen,
  output logic              resp_err,
  output logic [4:0]        resp_rd,
  output logic [DATA_W-1:0] resp_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int IDX_W = $clog2(DEPTH);

  heap_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        rd_q, rd_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_wen_q, resp_wen_d;
  logic              resp_err_q, resp_err_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic [DATA_W-1:0] heap_q [DEPTH];

  logic              we0, we1;
  logic [IDX_W-1:0]  wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;

  logic              req_bad;
  logic [IDX_W-1:0]  tail_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [IDX_W-1:0]  parent_idx;
  logic [IDX_W-1:0]  left_idx, right_idx, child_idx;
  logic [DATA_W-1:0] child_key;
  logic              down_swap;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign req_ready = (state_q == IDLE);

  assign resp_valid = resp_valid_q;
  assign resp_wen   = resp_wen_q;
  assign resp_err   = resp_err_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;

  assign req_bad    = (req_push == req_pop) || (req_push && full) || (req_pop && empty);
  assign tail_idx   = IDX_W'(count_q);
  assign last_idx   = IDX_W'(count_q - CNT_W'(1));
  assign parent_idx = (idx_q - IDX_W'(1)) >> 1;

  heap_child_sel #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_child_sel (
    .idx_i        (idx_q),
    .count_i      (count_q),
    .parent_key_i (heap_q[idx_q]),
    .left_key_i   (heap_q[left_idx]),
    .right_key_i  (heap_q[right_idx]),
    .left_idx_o   (left_idx),
    .right_idx_o  (right_idx),
    .child_idx_o  (child_idx),
    .child_key_o  (child_key),
    .swap_o       (down_swap)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    result_d     = result_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    resp_wen_d   = 1'b0;
    resp_err_d   = 1'b0;
    resp_rd_d    = '0;
    resp_data_d  = '0;
    we0          = 1'b0;
    wa0          = '0;
    wd0          = '0;
    we1          = 1'b0;
    wa1          = '0;
    wd1          = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rd_d    = req_rd;
          end else if (req_push) begin
            we0     = 1'b1;
            wa0     = tail_idx;
            wd0     = req_data;
            count_d = count_q + CNT_W'(1);
            idx_d   = tail_idx;
            rd_d    = req_rd;
            state_d = SIFT_UP;
          end else begin
            result_d = heap_q[0];
            we0      = 1'b1;
            wa0      = '0;
            wd0      = heap_q[last_idx];
            count_d  = count_q - CNT_W'(1);
            idx_d    = '0;
            rd_d     = req_rd;
            state_d  = SIFT_DOWN;
          end
        end
      end

      SIFT_UP: begin
        if (idx_q == '0 || heap_q[parent_idx] <= heap_q[idx_q]) begin
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          state_d      = IDLE;
        end else begin
          we0   = 1'b1;
          wa0   = parent_idx;
          wd0   = heap_q[idx_q];
          we1   = 1'b1;
          wa1   = idx_q;
          wd1   = heap_q[parent_idx];
          idx_d = parent_idx;
        end
      end

      SIFT_DOWN: begin
        if (!down_swap) begin
          resp_valid_d = 1'b1;
          resp_wen_d   = 1'b1;
          resp_rd_d    = rd_q;
          resp_data_d  = result_q;
          state_d      = IDLE;
        end else begin
          we0   = 1'b1;
          wa0   = idx_q;
          wd0   = child_key;
          we1   = 1'b1;
          wa1   = child_idx;
          wd1   = heap_q[idx_q];
          idx_d = child_idx;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      result_q     <= '0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_wen_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_wen_q   <= resp_wen_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Key storage is deliberately unreset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (we0) heap_q[wa0] <= wd0;
    if (we1) heap_q[wa1] <= wd1;
  end

endmodule

// File: tb/tb_heap_exec_unit.sv
// Randomized scoreboard bench for heap_exec_unit against a multiset reference model.
module tb_heap_exec_unit;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_push, req_pop;
  logic [DATA_W-1:0] req_data;
  logic [4:0]        req_rd;
  logic              resp_valid, resp_wen, resp_err;
  logic [4:0]        resp_rd;
  logic [DATA_W-1:0] resp_data;
  logic [CNT_W-1:0]  count;
  logic              empty, full;

  heap_exec_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_push(req_push), .req_pop(req_pop),
    .req_data(req_data), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_err(resp_err),
    .resp_rd(resp_rd), .resp_data(resp_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              err;
    logic              wen;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] model[$];
  int checks = 0, errors = 0;
  int cyc = 0, acc_t = 0, last_resp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      last_resp_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got err=%0b wen=%0b rd=%0d data=%0d, required none",
                 resp_err, resp_wen, resp_rd, resp_data);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_err, resp_wen, resp_rd, resp_data} !== mon_e) begin
          errors++;
          $display("FAIL resp: got err=%0b wen=%0b rd=%0d data=%0d, required err=%0b wen=%0b rd=%0d data=%0d",
                   resp_err, resp_wen, resp_rd, resp_data, mon_e.err, mon_e.wen, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Drives one request, updates the reference multiset and queues the expected response.
  task automatic issue(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic [4:0] rd);
    int   n, mi;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(req_ready), 1);
    req_valid = 1'b1; req_push = p; req_pop = q; req_data = d; req_rd = rd;
    e = '0;
    e.rd = rd;
    if (p == q || (p && model.size() == DEPTH) || (q && model.size() == 0)) begin
      e.err = 1'b1;
    end else if (p) begin
      model.push_back(d);
    end else begin
      mi = 0;
      for (int i = 1; i < model.size(); i++) if (model[i] < model[mi]) mi = i;
      e.wen  = 1'b1;
      e.data = model[mi];
      model.delete(mi);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_t = cyc - 1;
    req_valid = 1'b0; req_push = 1'b0; req_pop = 1'b0; req_data = '0; req_rd = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    chk("count", int'(count), model.size());
    chk("empty", int'(empty), int'(model.size() == 0));
    chk("full", int'(full), int'(model.size() == DEPTH));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [DATA_W-1:0] key;
    rst_n = 1'b0;
    req_valid = 1'b0; req_push = 1'b0; req_pop = 1'b0; req_data = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_empty", int'(empty), 1);
    rst_n = 1'b1;

    // Basic ordering
    issue(1, 0, 5, 1); issue(1, 0, 3, 2); issue(1, 0, 8, 3); issue(1, 0, 1, 4);
    wait_idle();
    chk("four_pushed", int'(count), 4);
    for (int i = 0; i < 4; i++) issue(0, 1, 0, 5'(10 + i));
    wait_idle();

    // Latency into empty and of the sole entry
    issue(1, 0, 42, 7);
    wait_idle();
    chk("push_empty_lat", last_resp_cyc - acc_t, 2);
    issue(0, 1, 0, 8);
    wait_idle();
    chk("pop_sole_lat", last_resp_cyc - acc_t, 2);

    // Fill with descending keys (each sifts to root), overflow, then drain
    for (int i = DEPTH - 1; i >= 0; i--) issue(1, 0, i, 5'(i));
    wait_idle();
    issue(1, 0, 99, 9);
    wait_idle();
    chk("overflow_lat", last_resp_cyc - acc_t, 1);
    chk("full_after_ovf", int'(full), 1);
    for (int i = 0; i < DEPTH; i++) issue(0, 1, 0, 5'(i));
    wait_idle();

    // Underflow and illegal encodings
    issue(0, 1, 0, 3);
    wait_idle();
    chk("underflow_lat", last_resp_cyc - acc_t, 1);
    issue(1, 1, 17, 4);
    issue(0, 0, 17, 5);
    wait_idle();

    // Duplicates
    issue(1, 0, 7, 1); issue(1, 0, 7, 2); issue(1, 0, 7, 3); issue(1, 0, 2, 4);
    for (int i = 0; i < 4; i++) issue(0, 1, 0, 5'(20 + i));
    wait_idle();

    // Randomized mix, drained only occasionally so requests run back-to-back
    for (int k = 0; k < 400; k++) begin
      r   = $urandom_range(0, 19);
      key = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 31));
      if (r == 0)      issue(1, 1, key, 5'($urandom_range(0, 31)));
      else if (r == 1) issue(0, 0, key, 5'($urandom_range(0, 31)));
      else if (r < 11) issue(1, 0, key, 5'($urandom_range(0, 31)));
      else             issue(0, 1, key, 5'($urandom_range(0, 31)));
      if (k % 8 == 7) wait_idle();
    end
    wait_idle();

    // Reset in the middle of a sift-down
    while (model.size() > 0) issue(0, 1, 0, 1);
    wait_idle();
    issue(1, 0, 10, 1); issue(1, 0, 20, 2); issue(1, 0, 30, 3); issue(1, 0, 40, 4);
    wait_idle();
    issue(0, 1, 0, 6);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_resp_valid", int'(resp_valid), 0);
    chk("midrst_ready", int'(req_ready), 1);
    sb.delete();
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1, 0, 12);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
